video_timing_gen: RTL and testbench

Free-running raster timing generator for the DVI output path. It produces the pixel-clock-domain `de`, `hsync` and `vsync` signals, plus the active pixel coordinates that the pixel source uses to fetch `red`/`grn`/`blu`. Its outputs drive the DVI generator's `de` and `ctrl0` inputs directly. `ctrl1` and `ctrl2` are tied to 0 by the integrator. All outputs are registered, so downstream TMDS encoders see glitch-free control.

---
 rtl/video_timing_gen.sv | 93 +++++++++
 tb/tb_video_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: de/hsync/vsync plus active pixel coordinates.
// Latency: outputs are registered, one cycle behind the internal (h_cnt, v_cnt) position.
// Backpressure: none; the raster advances every pixel clock once out of reset.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  ctrl0,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SBEG_C = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SEND_C = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SBEG_C = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SEND_C = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("video_timing_gen: raster totals must not exceed 4095");
    end
  endgenerate

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        de_n;
  logic        hs_n;
  logic        vs_n;

  always_comb begin
    h_last = (h_cnt == H_LAST_C);
    v_last = (v_cnt == V_LAST_C);
    de_n   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_n   = (h_cnt >= H_SBEG_C) && (h_cnt < H_SEND_C);
    // vsync spans whole lines, so its edges coincide with h_cnt == 0
    vs_n   = (v_cnt >= V_SBEG_C) && (v_cnt < V_SEND_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
      de          <= de_n;
      hsync       <= hs_n ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_n ? VSYNC_POL : ~VSYNC_POL;
      x           <= de_n ? h_cnt : 12'd0;
      y           <= de_n ? v_cnt : 12'd0;
      line_start  <= de_n && (h_cnt == 12'd0);
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

  assign ctrl0 = {vsync, hsync};

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-size and tiny rasters checked every cycle against a
// position-based model, with randomized asynchronous resets and literal spot checks.
module tb_video_timing_gen;

  localparam int HA_A = 640, HF_A = 16, HS_A = 96, HB_A = 48;
  localparam int VA_A = 480, VF_A = 10, VS_A = 2,  VB_A = 33;
  localparam bit HP_A = 1'b0, VP_A = 1'b0;
  localparam int HA_B = 4, HF_B = 1, HS_B = 2, HB_B = 1;
  localparam int VA_B = 3, VF_B = 1, VS_B = 1, VB_B = 1;
  localparam bit HP_B = 1'b1, VP_B = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic de_a, hsync_a, vsync_a, ls_a, fs_a;
  logic [1:0] ctrl0_a;
  logic [11:0] x_a, y_a;
  logic de_b, hsync_b, vsync_b, ls_b, fs_b;
  logic [1:0] ctrl0_b;
  logic [11:0] x_b, y_b;

  video_timing_gen dut_a (
    .clk(clk), .rst(rst), .de(de_a), .hsync(hsync_a), .vsync(vsync_a), .ctrl0(ctrl0_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
    .HSYNC_POL(HP_B), .VSYNC_POL(VP_B)
  ) dut_b (
    .clk(clk), .rst(rst), .de(de_b), .hsync(hsync_b), .vsync(vsync_b), .ctrl0(ctrl0_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  logic [30:0] vec_a, vec_b;
  assign vec_a = {de_a, hsync_a, vsync_a, ctrl0_a, x_a, y_a, ls_a, fs_a};
  assign vec_b = {de_b, hsync_b, vsync_b, ctrl0_b, x_b, y_b, ls_b, fs_b};

  int n_checks = 0;
  int n_pass = 0;
  // clock edges seen since the last reset release; edge k shows raster position k-1
  int cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", nm, act, exp, cnt - 1, $time);
  endtask

  // Expected output bundle from the linear pixel index since reset.
  function automatic logic [30:0] model(input int c, input int ha, hfp, hsw, hbp,
                                        input int va, vfp, vsw, vbp,
                                        input bit hp, vp, input bit in_rst);
    int ht, vt, p, h, v;
    bit d, hs, vs;
    if (in_rst || c == 0) return {1'b0, ~hp, ~vp, ~vp, ~hp, 12'd0, 12'd0, 2'b00};
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p  = (c - 1) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    d  = (h < ha) && (v < va);
    hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
    vs = (v >= va + vfp) && (v < va + vfp + vsw);
    return {d, hs ? hp : ~hp, vs ? vp : ~vp, vs ? vp : ~vp, hs ? hp : ~hp,
            d ? 12'(h) : 12'd0, d ? 12'(v) : 12'd0, d && (h == 0), (h == 0) && (v == 0)};
  endfunction

  function automatic logic [30:0] exp_a(input bit r);
    return model(cnt, HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, VB_A, HP_A, VP_A, r);
  endfunction

  function automatic logic [30:0] exp_b(input bit r);
    return model(cnt, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, VB_B, HP_B, VP_B, r);
  endfunction

  always @(negedge clk) begin
    check("cyc_a", {1'b0, vec_a}, {1'b0, exp_a(rst)});
    check("cyc_b", {1'b0, vec_b}, {1'b0, exp_b(rst)});
    check("de_hs_a", {31'd0, de_a && (hsync_a == HP_A)}, 32'd0);
    check("de_hs_b", {31'd0, de_b && (hsync_b == HP_B)}, 32'd0);
  end

  task automatic goto_cycle(input int c);
    while (cnt < c + 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic async_reset(input int offs, input int hold);
    #(offs) rst = 1'b1;
    #1;
    check("async_clr_a", {1'b0, vec_a}, {1'b0, exp_a(1'b1)});
    check("async_clr_b", {1'b0, vec_b}, {1'b0, exp_b(1'b1)});
    repeat (hold) @(posedge clk);
    release_rst();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl0_a", {30'd0, ctrl0_a}, 32'h3);
    check("rst_ctrl0_b", {30'd0, ctrl0_b}, 32'h0);
    check("rst_de_a", {31'd0, de_a}, 32'd0);
    release_rst();

    goto_cycle(0);
    check("first_de_a", {31'd0, de_a}, 32'd1);
    check("first_fs_a", {31'd0, fs_a}, 32'd1);
    check("first_ls_a", {31'd0, ls_a}, 32'd1);
    check("first_xy_a", {8'd0, x_a, y_a}, 32'd0);
    check("first_fs_b", {31'd0, fs_b}, 32'd1);
    goto_cycle(5);  check("b_hs_on5", {31'd0, hsync_b}, 32'd1);
    goto_cycle(6);  check("b_hs_on6", {31'd0, hsync_b}, 32'd1);
    goto_cycle(7);  check("b_hs_off7", {31'd0, hsync_b}, 32'd0);
    goto_cycle(31); check("b_vs_off31", {31'd0, vsync_b}, 32'd0);
    goto_cycle(32); check("b_vs_on32", {31'd0, vsync_b}, 32'd1);
    goto_cycle(39); check("b_vs_on39", {31'd0, vsync_b}, 32'd1);
    goto_cycle(40); check("b_vs_off40", {31'd0, vsync_b}, 32'd0);
    goto_cycle(47); check("b_wrap_pre_de", {31'd0, de_b}, 32'd0);
    goto_cycle(48);
    check("b_wrap_fs", {31'd0, fs_b}, 32'd1);
    check("b_wrap_de", {31'd0, de_b}, 32'd1);
    check("b_wrap_xy", {8'd0, x_b, y_b}, 32'd0);
    goto_cycle(639);
    check("a_de_last", {31'd0, de_a}, 32'd1);
    check("a_x_last", {20'd0, x_a}, 32'd639);
    goto_cycle(640);
    check("a_de_off", {31'd0, de_a}, 32'd0);
    check("a_x_blank", {20'd0, x_a}, 32'd0);
    goto_cycle(655); check("a_hs_pre", {31'd0, hsync_a}, 32'd1);
    goto_cycle(656); check("a_hs_start", {31'd0, hsync_a}, 32'd0);
    goto_cycle(751); check("a_hs_end", {31'd0, hsync_a}, 32'd0);
    goto_cycle(752); check("a_hs_post", {31'd0, hsync_a}, 32'd1);
    goto_cycle(800);
    check("a_ls_line1", {31'd0, ls_a}, 32'd1);
    check("a_y_line1", {20'd0, y_a}, 32'd1);
    check("a_x_line1", {20'd0, x_a}, 32'd0);

    goto_cycle(1100);
    check("a_mid_de", {31'd0, de_a}, 32'd1);
    check("a_mid_x", {20'd0, x_a}, 32'd300);
    async_reset(2, 2);
    check("a_mid_ctrl0", {30'd0, ctrl0_a}, 32'h3);
    goto_cycle(0);
    check("restart_fs_a", {31'd0, fs_a}, 32'd1);
    check("restart_xy_a", {8'd0, x_a, y_a}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(20, 3000)) @(posedge clk);
      async_reset($urandom_range(1, 3), $urandom_range(0, 3));
    end
    repeat (2000) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
